sprite_compositor: RTL and testbench

Parametrised N-channel sprite renderer for the VGA output path. It replaces the fixed two-sprite screen logic with a layered compositor. Features: generic sprite count, per-sprite power-of-two scaling, per-sprite colour, loadable 1-bpp bitmaps, frame-synchronous (tear-free) position updates, and per-frame sprite collision flags. It sits between the VGA timing generator (pixel coordinates in) and the DAC outputs (VGA_R/G/B).

---
 rtl/sprite_compositor.sv | 198 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Layered 1-bpp sprite compositor for the VGA path: shadowed per-sprite geometry/colour,
// two-stage pixel pipeline (geometry, then bitmap fetch + priority pick), per-frame collision flags.
module sprite_compositor #(
  parameter int          N_SPRITES = 4,
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 16,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic                 VGA_CLK,
  input  logic                 reset,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 pixel_valid,
  input  logic                 frame_start,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_sprite,
  input  logic [2:0]           cfg_field,
  input  logic [3:0]           cfg_row,
  input  logic [23:0]          cfg_data,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 pix_valid_out,
  output logic [N_SPRITES-1:0] collision
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  // Shadow (CPU-visible) and active (frame-stable) sprite state
  logic [9:0]       sh_x_q   [N_SPRITES];
  logic [9:0]       sh_y_q   [N_SPRITES];
  logic [1:0]       sh_sh_q  [N_SPRITES];
  logic             sh_en_q  [N_SPRITES];
  logic [23:0]      sh_col_q [N_SPRITES];
  logic [9:0]       act_x_q  [N_SPRITES];
  logic [9:0]       act_y_q  [N_SPRITES];
  logic [1:0]       act_sh_q [N_SPRITES];
  logic             act_en_q [N_SPRITES];
  logic [23:0]      act_col_q[N_SPRITES];
  logic [SPR_W-1:0] bmp_q    [N_SPRITES][SPR_H];

  // Stage 1 registers and their next-state values
  logic                 s1_valid_q;
  logic [N_SPRITES-1:0] s1_in_q, s1_in_d;
  logic [COL_W-1:0]     s1_col_q [N_SPRITES];
  logic [COL_W-1:0]     s1_col_d [N_SPRITES];
  logic [ROW_W-1:0]     s1_row_q [N_SPRITES];
  logic [ROW_W-1:0]     s1_row_d [N_SPRITES];
  logic [23:0]          s1_color_q[N_SPRITES];

  // Stage 2 / output registers
  logic [23:0]          rgb_q, rgb_d;
  logic                 pv_q;
  logic [N_SPRITES-1:0] acc_q, acc_d;
  logic [N_SPRITES-1:0] coll_q, coll_d;

  logic [10:0]          dx     [N_SPRITES];
  logic [10:0]          dy     [N_SPRITES];
  logic [10:0]          lim_x  [N_SPRITES];
  logic [10:0]          lim_y  [N_SPRITES];
  logic [SPR_W-1:0]     row_bits[N_SPRITES];
  logic [COL_W-1:0]     bit_idx[N_SPRITES];
  logic [N_SPRITES-1:0] opaque;
  logic                 hit;
  int                   n_opaque;

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x_q[i]    <= '0;
        sh_y_q[i]    <= '0;
        sh_sh_q[i]   <= '0;
        sh_en_q[i]   <= 1'b0;
        sh_col_q[i]  <= '0;
        act_x_q[i]   <= '0;
        act_y_q[i]   <= '0;
        act_sh_q[i]  <= '0;
        act_en_q[i]  <= 1'b0;
        act_col_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        // Copy uses the pre-write shadow, so a coincident write lands one frame later
        if (frame_start) begin
          act_x_q[i]   <= sh_x_q[i];
          act_y_q[i]   <= sh_y_q[i];
          act_sh_q[i]  <= sh_sh_q[i];
          act_en_q[i]  <= sh_en_q[i];
          act_col_q[i] <= sh_col_q[i];
        end
        if (cfg_we && cfg_sprite == 3'(i)) begin
          case (cfg_field)
            3'd0:    sh_x_q[i]   <= cfg_data[9:0];
            3'd1:    sh_y_q[i]   <= cfg_data[9:0];
            3'd2:    sh_sh_q[i]  <= cfg_data[1:0];
            3'd3:    sh_en_q[i]  <= cfg_data[0];
            3'd4:    sh_col_q[i] <= cfg_data;
            default: ;
          endcase
        end
      end
    end
  end

  // Bitmaps are unshadowed and survive reset
  always_ff @(posedge VGA_CLK) begin
    if (!reset && cfg_we && cfg_field == 3'd5) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        for (int r = 0; r < SPR_H; r++) begin
          if (cfg_sprite == 3'(i) && cfg_row == 4'(r)) bmp_q[i][r] <= cfg_data[SPR_W-1:0];
        end
      end
    end
  end

  // Stage 1: 11-bit differences keep negative offsets from wrapping into the sprite
  always_comb begin
    s1_in_d = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      dx[i]       = {1'b0, pixel_x} - {1'b0, act_x_q[i]};
      dy[i]       = {1'b0, pixel_y} - {1'b0, act_y_q[i]};
      lim_x[i]    = 11'(SPR_W) << act_sh_q[i];
      lim_y[i]    = 11'(SPR_H) << act_sh_q[i];
      s1_in_d[i]  = act_en_q[i] && !dx[i][10] && (dx[i] < lim_x[i]) &&
                    !dy[i][10] && (dy[i] < lim_y[i]);
      s1_col_d[i] = COL_W'(dx[i] >> act_sh_q[i]);
      s1_row_d[i] = ROW_W'(dy[i] >> act_sh_q[i]);
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_in_q    <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_col_q[i]   <= '0;
        s1_row_q[i]   <= '0;
        s1_color_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= pixel_valid;
      s1_in_q    <= s1_in_d;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_col_q[i]   <= s1_col_d[i];
        s1_row_q[i]   <= s1_row_d[i];
        s1_color_q[i] <= act_col_q[i];
      end
    end
  end

  // Stage 2: bitmap fetch (MSB is leftmost), lowest index wins
  always_comb begin
    opaque   = '0;
    n_opaque = 0;
    rgb_d    = BG_COLOR;
    for (int i = 0; i < N_SPRITES; i++) begin
      row_bits[i] = bmp_q[i][s1_row_q[i]];
      bit_idx[i]  = COL_W'(SPR_W - 1) - s1_col_q[i];
      opaque[i]   = s1_in_q[i] && row_bits[i][bit_idx[i]];
      if (opaque[i]) n_opaque = n_opaque + 1;
    end
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_d = s1_color_q[i];
    end
    if (!s1_valid_q) rgb_d = '0;
    hit    = s1_valid_q && (n_opaque >= 2);
    acc_d  = acc_q;
    coll_d = coll_q;
    if (frame_start) begin
      coll_d = acc_q;
      acc_d  = hit ? opaque : '0;
    end else if (hit) begin
      acc_d = acc_q | opaque;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      rgb_q  <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
      coll_q <= '0;
    end else begin
      rgb_q  <= rgb_d;
      pv_q   <= s1_valid_q;
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign VGA_R         = rgb_q[23:16];
  assign VGA_G         = rgb_q[15:8];
  assign VGA_B         = rgb_q[7:0];
  assign pix_valid_out = pv_q;
  assign collision     = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed probes plus randomized configs/pixels, checked against
// a screen-level reference model that computes each pixel from sprite rectangles and bitmaps.
module tb_sprite_compositor;

  localparam int          N  = 4;
  localparam int          SW = 16;
  localparam int          SH = 16;
  localparam logic [23:0] BG = 24'h000000;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   px, py;
  logic         pv, fs, we;
  logic [2:0]   spr, fld;
  logic [3:0]   row;
  logic [23:0]  data;
  logic [7:0]   vga_r, vga_g, vga_b;
  logic         pvo;
  logic [N-1:0] coll;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .BG_COLOR(BG)) dut (
    .VGA_CLK(clk), .reset(reset), .pixel_x(px), .pixel_y(py), .pixel_valid(pv),
    .frame_start(fs), .cfg_we(we), .cfg_sprite(spr), .cfg_field(fld), .cfg_row(row),
    .cfg_data(data), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .pix_valid_out(pvo), .collision(coll)
  );

  // Reference model state
  int            m_sx[N], m_sy[N], m_ssh[N], m_sen[N];
  int            m_ax[N], m_ay[N], m_ash[N], m_aen[N];
  logic [23:0]   m_scol[N], m_acol[N];
  logic [SW-1:0] m_bmp[N][SH];
  logic [N-1:0]  m_acc, m_coll, m_pend;
  logic [24:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] opaque_at(int x, int y);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) begin
      int sc = 1 << m_ash[i];
      int ddx = x - m_ax[i];
      int ddy = y - m_ay[i];
      if (m_aen[i] != 0 && ddx >= 0 && ddx < SW * sc && ddy >= 0 && ddy < SH * sc)
        if (m_bmp[i][ddy / sc][SW - 1 - ddx / sc]) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [23:0] colour_of(logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return m_acol[i];
    return BG;
  endfunction

  // One clock: update the model from the current inputs, clock, then compare outputs
  task automatic step();
    logic [N-1:0] m;
    logic [24:0]  e;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_ssh[i] = 0; m_sen[i] = 0; m_scol[i] = '0;
        m_ax[i] = 0; m_ay[i] = 0; m_ash[i] = 0; m_aen[i] = 0; m_acol[i] = '0;
      end
      m_acc = '0; m_coll = '0; m_pend = '0;
      exp_q.delete();
      exp_q.push_back(25'h0);
      exp_q.push_back(25'h0);
    end else begin
      m = pv ? opaque_at(int'(px), int'(py)) : '0;
      exp_q.push_back(pv ? {1'b1, colour_of(m)} : 25'h0);
      if (fs) begin
        m_coll = m_acc;
        m_acc  = m_pend;
      end else begin
        m_acc = m_acc | m_pend;
      end
      m_pend = ($countones(m) >= 2) ? m : '0;
      if (fs) begin
        for (int i = 0; i < N; i++) begin
          m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_ash[i] = m_ssh[i];
          m_aen[i] = m_sen[i]; m_acol[i] = m_scol[i];
        end
      end
      if (we && int'(spr) < N) begin
        case (fld)
          3'd0: m_sx[spr] = int'(data[9:0]);
          3'd1: m_sy[spr] = int'(data[9:0]);
          3'd2: m_ssh[spr] = int'(data[1:0]);
          3'd3: m_sen[spr] = int'(data[0]);
          3'd4: m_scol[spr] = data;
          3'd5: if (int'(row) < SH) m_bmp[spr][row] = data[SW-1:0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("valid", 32'(pvo), 32'(e[24]));
    check("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, e[23:0]});
    check("coll", 32'(coll), 32'(m_coll));
  endtask

  task automatic idle();
    pv = 1'b0; fs = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic pix(input int x, input int y);
    pv = 1'b1; fs = 1'b0; we = 1'b0; px = 10'(x); py = 10'(y);
    step();
  endtask

  task automatic frame();
    pv = 1'b0; fs = 1'b1; we = 1'b0;
    step();
    fs = 1'b0;
  endtask

  task automatic wr(input int s, input int f, input int r, input logic [23:0] d, input logic with_fs);
    pv = 1'b0; fs = with_fs; we = 1'b1;
    spr = 3'(s); fld = 3'(f); row = 4'(r); data = d;
    step();
    we = 1'b0; fs = 1'b0;
  endtask

  task automatic sweep(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) pix(x, y);
  endtask

  task automatic fill_bmp(input int s, input logic [23:0] d);
    for (int r = 0; r < SH; r++) wr(s, 5, r, d, 1'b0);
  endtask

  // Drive one pixel, then one idle cycle so the probed pixel sits on the outputs
  task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
    pix(x, y);
    idle();
    check(tag, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp});
  endtask

  initial begin
    reset = 1'b1; pv = 1'b0; fs = 1'b0; we = 1'b0;
    px = '0; py = '0; spr = '0; fld = '0; row = '0; data = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    for (int s = 0; s < N; s++) fill_bmp(s, 24'h0);

    // Nothing enabled: background while valid, zero otherwise
    pix(0, 0);
    idle();
    check("bg_valid", 32'(pvo), 32'd1);
    check("bg_rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, BG});
    idle();
    check("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);

    // Sprite 0, 1x scale, solid red at (100,50)
    wr(0, 0, 0, 24'd100, 1'b0);
    wr(0, 1, 0, 24'd50, 1'b0);
    wr(0, 2, 0, 24'd0, 1'b0);
    wr(0, 4, 0, 24'hFF0000, 1'b0);
    wr(0, 3, 0, 24'd1, 1'b0);
    fill_bmp(0, 24'h00FFFF);
    frame();
    sweep(50, 95, 120);
    probe("x100", 100, 50, 24'hFF0000);
    probe("x115", 115, 50, 24'hFF0000);
    probe("x99", 99, 50, BG);
    probe("x116", 116, 50, BG);

    // 4x scale, top row only the leftmost bitmap pixel
    wr(0, 2, 0, 24'd2, 1'b0);
    wr(0, 5, 0, 24'h008000, 1'b0);
    frame();
    sweep(50, 96, 168);
    sweep(54, 96, 168);
    probe("s2_103_50", 103, 50, 24'hFF0000);
    probe("s2_104_50", 104, 50, BG);
    probe("s2_163_113", 163, 113, 24'hFF0000);
    probe("s2_164_60", 164, 60, BG);
    probe("s2_100_114", 100, 114, BG);

    // Shadowed position update
    wr(0, 2, 0, 24'd0, 1'b0);
    wr(0, 5, 0, 24'h00FFFF, 1'b0);
    frame();
    wr(0, 0, 0, 24'd200, 1'b0);
    probe("old_pos", 100, 52, 24'hFF0000);
    probe("new_pos_early", 200, 52, BG);
    frame();
    probe("new_pos", 200, 52, 24'hFF0000);
    probe("old_pos_gone", 100, 52, BG);
    wr(0, 0, 0, 24'd300, 1'b1);
    probe("coincident_old", 200, 52, 24'hFF0000);
    frame();
    probe("coincident_new", 300, 52, 24'hFF0000);

    // Overlap red over green and collision flags
    wr(0, 0, 0, 24'd110, 1'b0);
    wr(1, 0, 0, 24'd115, 1'b0);
    wr(1, 1, 0, 24'd55, 1'b0);
    wr(1, 4, 0, 24'h00FF00, 1'b0);
    wr(1, 3, 0, 24'd1, 1'b0);
    fill_bmp(1, 24'h00FFFF);
    frame();
    sweep(60, 105, 135);
    probe("overlap", 120, 60, 24'hFF0000);
    probe("green_only", 128, 60, 24'h00FF00);
    idle();
    frame();
    check("coll_overlap", 32'(coll), 32'h3);
    wr(1, 0, 0, 24'd400, 1'b0);
    frame();
    sweep(60, 105, 135);
    sweep(60, 395, 420);
    frame();
    check("coll_clear", 32'(coll), 32'h0);

    // Right-edge clipping
    wr(0, 3, 0, 24'd0, 1'b0);
    wr(1, 3, 0, 24'd0, 1'b0);
    wr(2, 0, 0, 24'd630, 1'b0);
    wr(2, 1, 0, 24'd200, 1'b0);
    wr(2, 4, 0, 24'h0000FF, 1'b0);
    wr(2, 3, 0, 24'd1, 1'b0);
    fill_bmp(2, 24'h00FFFF);
    frame();
    sweep(205, 625, 639);
    sweep(205, 0, 5);
    probe("clip_639", 639, 205, 24'h0000FF);
    probe("clip_0", 0, 205, BG);
    probe("clip_629", 629, 205, BG);

    // Reset in the middle of a line
    sweep(205, 630, 635);
    reset = 1'b1;
    pv = 1'b1;
    step();
    check("rst_valid", 32'(pvo), 32'd0);
    check("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check("rst_coll", 32'(coll), 32'h0);
    reset = 1'b0;
    sweep(205, 630, 639);
    idle();

    // Randomized configuration and pixel traffic
    for (int f = 0; f < 40; f++) begin
      int nw = $urandom_range(2, 6);
      for (int k = 0; k < nw; k++) begin
        int s = $urandom_range(0, 7);
        int fl = $urandom_range(0, 7);
        logic [23:0] d = 24'($urandom());
        if (fl == 0) d[9:0] = 10'($urandom_range(0, 650));
        if (fl == 1) d[9:0] = 10'($urandom_range(0, 490));
        if (fl == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(s, fl, $urandom_range(0, 15), d, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 3), 0, 0, 24'($urandom_range(0, 639)), 1'b1);
      else frame();
      for (int p = 0; p < 40; p++) begin
        int k = $urandom_range(0, N - 1);
        int x = m_ax[k] + $urandom_range(0, 140) - 10;
        int y = m_ay[k] + $urandom_range(0, 140) - 10;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        if ($urandom_range(0, 9) == 0) idle();
        else pix(x, y);
      end
      idle();
    end
    frame();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
